// File: rtl/pcie_rq_seq_num_fifo.sv
// pcie_rq_seq_num_fifo: merges two non-backpressurable RQ sequence-number ports into one ordered FWFT stream
module pcie_rq_seq_num_fifo #(
  parameter int RQ_SEQ_NUM_WIDTH = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RQ_SEQ_NUM_WIDTH-1:0]   s_axis_rq_seq_num_0,
  input  logic                          s_axis_rq_seq_num_valid_0,
  input  logic [RQ_SEQ_NUM_WIDTH-1:0]   s_axis_rq_seq_num_1,
  input  logic                          s_axis_rq_seq_num_valid_1,
  output logic [RQ_SEQ_NUM_WIDTH-1:0]   m_axis_seq_num,
  output logic                          m_axis_seq_num_valid,
  input  logic                          m_axis_seq_num_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count, space;
  logic [RQ_SEQ_NUM_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [RQ_SEQ_NUM_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic we0, we1, rd_en, overflow_q, overflow_d;
  logic [AW-1:0] wa1;
  logic [1:0] drops;
  logic [DROP_CNT_WIDTH:0] drop_sum;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  // admission from registered occupancy only (a same-cycle read frees no space), port 0 first
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    space = PW'(FIFO_DEPTH) - count;
    we0 = s_axis_rq_seq_num_valid_0 && (space >= PW'(1));
    we1 = s_axis_rq_seq_num_valid_1 && (space >= (we0 ? PW'(2) : PW'(1)));
    wa1 = wr_ptr_q[AW-1:0] + AW'(we0);
    wr_ptr_d = wr_ptr_q + PW'(we0) + PW'(we1);
    rd_en = (count != '0) && m_axis_seq_num_ready;
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    drops = 2'(s_axis_rq_seq_num_valid_0 && !we0) + 2'(s_axis_rq_seq_num_valid_1 && !we1);
    overflow_d = drops != 2'd0;
    drop_sum = {1'b0, drop_count_q} + (DROP_CNT_WIDTH+1)'(drops);
    drop_count_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
  end

  // storage update: port 1 lands in the slot after port 0 when both are admitted
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[wr_ptr_q[AW-1:0]] = s_axis_rq_seq_num_0;
    if (we1) mem_d[wa1] = s_axis_rq_seq_num_1;
  end

  // pointers and drop accounting, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // entry storage is not reset; contents are only visible while valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fifo_count = count;
  assign m_axis_seq_num_valid = count != '0;
  assign m_axis_seq_num = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_pcie_rq_seq_num_fifo.sv
// tb_pcie_rq_seq_num_fifo: table vectors, directed corners and random streaming against a queue model
module tb_pcie_rq_seq_num_fifo;
  localparam int W = 6;
  localparam int D = 16;
  localparam int DW = 16;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0, rdy = 1'b0;
  logic [W-1:0] m_data;
  logic m_valid, ovf;
  logic [CW-1:0] cnt;
  logic [DW-1:0] drop;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  int m_drop = 0;
  logic m_ovf = 1'b0;

  pcie_rq_seq_num_fifo #(.RQ_SEQ_NUM_WIDTH(W), .FIFO_DEPTH(D), .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_rq_seq_num_0(d0),
    .s_axis_rq_seq_num_valid_0(v0),
    .s_axis_rq_seq_num_1(d1),
    .s_axis_rq_seq_num_valid_1(v1),
    .m_axis_seq_num(m_data),
    .m_axis_seq_num_valid(m_valid),
    .m_axis_seq_num_ready(rdy),
    .fifo_count(cnt),
    .overflow(ovf),
    .drop_count(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic a0, input logic [W-1:0] b0, input logic a1, input logic [W-1:0] b1, input logic r);
    int space;
    int nd;
    bit w0, w1;
    @(negedge clk);
    v0 = a0; d0 = b0; v1 = a1; d1 = b1; rdy = r;
    @(posedge clk);
    #1;
    space = D - q.size();
    w0 = a0 && space >= 1;
    w1 = a1 && space >= (w0 ? 2 : 1);
    if (q.size() != 0 && r) void'(q.pop_front());
    if (w0) q.push_back(b0);
    if (w1) q.push_back(b1);
    nd = int'(a0 && !w0) + int'(a1 && !w1);
    m_ovf = nd != 0;
    m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    chk("valid", 32'(m_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("data", 32'(m_data), 32'(q[0]));
    chk("count", 32'(cnt), 32'(q.size()));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("drop_count", 32'(drop), 32'(m_drop));
  endtask

  typedef struct {
    logic a0; logic [W-1:0] b0; logic a1; logic [W-1:0] b1; logic r;
    logic ev; logic [W-1:0] ed; int ec;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int sent, cyc;
    logic [W-1:0] nxt;
    tbl[0] = '{1'b1, 6'h05, 1'b0, 6'h00, 1'b0, 1'b1, 6'h05, 1};
    tbl[1] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1, 6'h05, 1};
    tbl[2] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 0};
    tbl[3] = '{1'b1, 6'h0A, 1'b1, 6'h0B, 1'b1, 1'b1, 6'h0A, 2};
    tbl[4] = '{1'b0, 6'h00, 1'b1, 6'h0C, 1'b1, 1'b1, 6'h0B, 2};
    tbl[5] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b1, 6'h0C, 1};
    tbl[6] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 0};

    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(m_valid), 0);
    chk("reset_count", 32'(cnt), 0);
    chk("reset_drop", 32'(drop), 0);
    chk("reset_overflow", 32'(ovf), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].r);
      chk("tbl_valid", 32'(m_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_data", 32'(m_data), 32'(tbl[i].ed));
      chk("tbl_count", 32'(cnt), 32'(tbl[i].ec));
      chk("tbl_overflow", 32'(ovf), 0);
    end

    for (int i = 0; i < 7; i++) step(1'b1, 6'(2 * i), 1'b1, 6'(2 * i + 1), 1'b0);
    step(1'b1, 6'h20, 1'b1, 6'h21, 1'b0);
    chk("fill_count", 32'(cnt), 16);
    chk("fill_no_overflow", 32'(ovf), 0);
    step(1'b1, 6'h22, 1'b1, 6'h23, 1'b0);
    chk("full_overflow", 32'(ovf), 1);
    chk("full_drop", 32'(drop), 2);
    chk("full_count", 32'(cnt), 16);
    step(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    chk("overflow_pulse_end", 32'(ovf), 0);
    for (int k = 0; k < 16; k++) begin
      chk("drain_data", 32'(m_data), (k < 14) ? k : 32'h20 + k - 14);
      step(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    end
    chk("drain_empty", 32'(m_valid), 0);

    for (int i = 0; i < 7; i++) step(1'b1, 6'h10 + 6'(2 * i), 1'b1, 6'h11 + 6'(2 * i), 1'b0);
    step(1'b1, 6'h1E, 1'b0, 6'h00, 1'b0);
    chk("partial_count15", 32'(cnt), 15);
    step(1'b1, 6'h30, 1'b1, 6'h31, 1'b0);
    chk("partial_count16", 32'(cnt), 16);
    chk("partial_drop", 32'(drop), 3);
    chk("partial_overflow", 32'(ovf), 1);
    step(1'b1, 6'h3A, 1'b0, 6'h00, 1'b1);
    chk("full_read_count", 32'(cnt), 15);
    chk("full_read_drop", 32'(drop), 4);
    chk("full_read_overflow", 32'(ovf), 1);
    chk("full_read_head", 32'(m_data), 32'h11);
    for (int k = 0; k < 40 && m_valid; k++) step(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    chk("partial_drain_empty", 32'(m_valid), 0);

    sent = 0; cyc = 0; nxt = '0;
    while (sent < 100 && cyc < 2000) begin
      int sp = D - q.size();
      int pick = $urandom_range(0, 2);
      logic r = 1'($urandom_range(0, 1));
      if (pick == 2 && sp >= 2 && sent <= 98) begin
        step(1'b1, nxt, 1'b1, nxt + 6'd1, r);
        nxt = nxt + 6'd2; sent += 2;
      end else if (pick == 1 && sp >= 1) begin
        if ($urandom_range(0, 1) == 1) step(1'b1, nxt, 1'b0, 6'h00, r);
        else step(1'b0, 6'h00, 1'b1, nxt, r);
        nxt = nxt + 6'd1; sent += 1;
      end else begin
        step(1'b0, 6'h00, 1'b0, 6'h00, r);
      end
      cyc++;
    end
    chk("wrap_sent", 32'(sent), 100);
    for (int k = 0; k < 40 && m_valid; k++) step(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    chk("wrap_empty", 32'(m_valid), 0);
    chk("wrap_no_drops", 32'(drop), 4);

    for (int i = 0; i < 4; i++) step(1'b1, 6'(i), 1'b1, 6'(i + 8), 1'b0);
    chk("pre_reset_count", 32'(cnt), 8);
    #2;
    v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(m_valid), 0);
    chk("async_reset_count", 32'(cnt), 0);
    chk("async_reset_drop", 32'(drop), 0);
    q.delete(); m_drop = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 6'h3F, 1'b0, 6'h00, 1'b0);
    chk("post_reset_head", 32'(m_data), 32'h3F);
    chk("post_reset_count", 32'(cnt), 1);
    step(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    chk("post_reset_empty", 32'(m_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_rq_seq_num_fifo.md
# pcie_rq_seq_num_fifo

Merges the two PCIe hard-IP RQ transmit sequence-number reporting ports (`s_axis_rq_seq_num_0/1`) into a single ordered, flow-controlled stream for the DMA write/read engines' flow-control and completion-tracking logic. The block sits between the UltraScale+ PCIe core's sequence-number outputs and the DMA bench's TX accounting. The hard IP cannot be back-pressured, so the block buffers up to `FIFO_DEPTH` entries, accepts two entries per cycle and emits one per cycle. It flags and counts any entries it has to drop.

## Interface
Parameters:
- `RQ_SEQ_NUM_WIDTH`, default 6: sequence number width.
- `FIFO_DEPTH`, default 16: entry count; power of two, at least 4.
- `DROP_CNT_WIDTH`, default 16: width of the saturating drop counter.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `s_axis_rq_seq_num_0` in `RQ_SEQ_NUM_WIDTH`: port 0 sequence number.
- `s_axis_rq_seq_num_valid_0` in 1: port 0 valid. No ready signal exists.
- `s_axis_rq_seq_num_1` in `RQ_SEQ_NUM_WIDTH`: port 1 sequence number.
- `s_axis_rq_seq_num_valid_1` in 1: port 1 valid.
- `m_axis_seq_num` out `RQ_SEQ_NUM_WIDTH`: head entry.
- `m_axis_seq_num_valid` out 1: head entry is valid.
- `m_axis_seq_num_ready` in 1: consumer accepts the head entry.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `overflow` out 1: one-cycle pulse when at least one entry is dropped in a cycle.
- `drop_count` out `DROP_CNT_WIDTH`: saturating count of dropped entries.

## Operation
- Storage is a circular buffer `mem[FIFO_DEPTH]` with `wr_ptr` and `rd_ptr`. Each pointer is `$clog2(FIFO_DEPTH)+1` bits and wraps naturally.
- Occupancy: `count = wr_ptr - rd_ptr`, computed modulo the pointer width. Full when `count == FIFO_DEPTH`; empty when `count == 0`.
- Write admission, evaluated each cycle from the registered count:
  - `space = FIFO_DEPTH - count`.
  - A read in the same cycle does NOT add space.
  - Port 0 is considered first, then port 1.
  - If port 0 is valid and `space >= 1`, write port 0 to `mem[wr_ptr]`.
  - If port 1 is valid and enough space remains after port 0's write (`space >= 2` if port 0 wrote, else `space >= 1`), write port 1 to the next slot.
  - `wr_ptr` advances by 0, 1 or 2.
- Ordering: when both ports are valid in the same cycle, the port 0 entry always precedes the port 1 entry in the output stream.
- Drops:
  - A valid input that is not admitted is discarded.
  - `overflow` pulses high for that cycle.
  - `drop_count` adds 1 or 2 and saturates at all-ones.
- Read side is first-word-fall-through:
  - `m_axis_seq_num_valid = (count != 0)`.
  - `m_axis_seq_num = mem[rd_ptr[$clog2(FIFO_DEPTH)-1:0]]`.
  - A transfer occurs when valid and ready are both high; `rd_ptr` then advances by 1.
- No state machine beyond the pointers. `drop_count` is cleared only by reset.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `wr_ptr`, `rd_ptr`, `drop_count` and `overflow` are 0, so `m_axis_seq_num_valid = 0` and `fifo_count = 0`.
  - `mem` contents are not reset; `m_axis_seq_num` is don't-care while valid is 0.
- Reset deassertion is assumed to be synchronized externally. Inputs in the first cycle after release are processed normally.
- Reset mid-stream: all buffered entries are lost and `drop_count` is cleared. No output is valid until a new write.
- Latency: an entry written on rising edge N appears at `m_axis_seq_num` with valid high after edge N, i.e. one cycle after its input was valid. There is no combinational path from input to output.
- `fifo_count`, `overflow` and `drop_count` are registered and update on the same edge as the pointers.
- Throughput: two writes and one read per cycle are sustained until full.
- `m_axis_seq_num` and `m_axis_seq_num_valid` remain stable while valid is high and ready is low.

## Test plan
- **Single entry:** after reset, port 0 presents 6'h05 for one cycle, with ready held low. One cycle later valid=1, data=05 and count=1. Ready pulsed for one cycle then gives valid=0 and count=0.
- **Dual-port ordering:** ports 0 and 1 present 6'h0A and 6'h0B in the same cycle, then 6'h0C on port 1 alone. With ready held high, the output sequence is 0A, 0B, 0C on consecutive cycles and `overflow` never asserts.
- **Fill and drop:**
  - With ready low, write 7 dual-port pairs (14 entries), then the pair 20/21 giving count=16, then the pair 22/23.
  - Required response: 22 and 23 are dropped, `overflow` pulses once and `drop_count`=2.
  - Drain: the output holds the 16 entries in order, ending 20, 21.
- **Partial space:**
  - With count=15 and ready low, present 30/31 on ports 0/1 → 30 is stored, 31 is dropped, `drop_count`+1 and count=16.
  - With count=16, ready high and one port 0 write → the write is dropped (a same-cycle read does not free space) and count=15.
- **Wrap-around:** stream 100 entries with an incrementing pattern (mod 64) through single and dual writes, with ready randomly toggled and no overflow. The output must match input order exactly across multiple pointer wraps.
- **Reset mid-operation:** with count=8, pulse `rst_n` low asynchronously between clock edges. Outputs immediately give valid=0, count=0 and `drop_count`=0. A subsequent write of 6'h3F emerges as the first output.
